run_length_detector: RTL and testbench

Parametrised serial run detector. It samples a 1-bit input `w` on qualified clock edges and asserts `z` while the most recent `RUN_LEN` samples are all 0 or all 1. It also reports the current run polarity and length, and emits a one-cycle pulse on each new detection. It sits behind the switch/key debounce logic of the lab top levels and drives LEDs directly; the optional per-polarity event counters feed the 7-segment display path.

---
 rtl/run_det_pkg.sv | 14 +
 rtl/sat_counter.sv | 29 ++
 rtl/run_length_detector.sv | 125 ++++++++++++
 tb/tb_run_length_detector.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/run_det_pkg.sv
// Shared types and limits for the serial run-length detector.
package run_det_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN0    = 2'd1,
      RUN1    = 2'd2,
      ILLEGAL = 2'd3
   } run_state_t;

   localparam int unsigned RUN_LEN_MIN = 32'd2;
   localparam int unsigned RUN_LEN_MAX = 32'd255;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and synchronous active-low reset.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   logic [W-1:0] count_r;

   // Clear has priority over increment; the count sticks at all-ones.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_r <= '0;
      end else if (clr) begin
         count_r <= '0;
      end else if (inc && (count_r != {W{1'b1}})) begin
         count_r <= count_r + W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/run_length_detector.sv
// Serial run detector: flags RUN_LEN consecutive equal samples of w.
// Optional per-polarity event counters are built with `define RUN_DET_EVENT_CNT_EN.
module run_length_detector
   import run_det_pkg::*;
#(
   parameter int unsigned RUN_LEN = 4,
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned LEN_W   = $clog2(RUN_LEN + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             w,
   input  logic             clear_cnt,
   output logic             z,
   output logic             z_pulse,
   output logic             run_val,
   output logic [LEN_W-1:0] run_len,
   output logic [1:0]       state
`ifdef RUN_DET_EVENT_CNT_EN
   ,
   output logic [CNT_W-1:0] hit0_cnt,
   output logic [CNT_W-1:0] hit1_cnt
`endif
);

   if ((RUN_LEN < RUN_LEN_MIN) || (RUN_LEN > RUN_LEN_MAX)) begin : g_bad_run_len
      $error("run_length_detector: RUN_LEN must lie in 2..255");
   end

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(RUN_LEN);
   localparam logic [LEN_W-1:0] LEN_PRE = LEN_W'(RUN_LEN - 1);

   run_state_t       state_r, state_s;
   logic [LEN_W-1:0] len_r, len_s;
   logic             z_r, z_s;
   logic             pulse_r, pulse_s;
   logic             run_val_r;

   // Next-state, saturating run length and the detection pulse condition.
   always_comb begin
      state_s = state_r;
      len_s   = len_r;
      pulse_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (en) begin
               state_s = w ? RUN1 : RUN0;
               len_s   = LEN_W'(1);
            end else begin
               state_s = state_r;
            end
         end
         RUN0, RUN1: begin
            if (!en) begin
               state_s = state_r;
            end else if (w == (state_r == RUN1)) begin
               if (len_r < LEN_MAX) begin
                  len_s = len_r + LEN_W'(1);
               end else begin
                  len_s = len_r;
               end
               pulse_s = (len_r == LEN_PRE);
            end else begin
               state_s = w ? RUN1 : RUN0;
               len_s   = LEN_W'(1);
            end
         end
         default: begin
            state_s = IDLE;
            len_s   = '0;
         end
      endcase
      z_s = (state_s != IDLE) && (len_s == LEN_MAX);
   end

   // All visible outputs come straight from these registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r   <= IDLE;
         len_r     <= '0;
         z_r       <= 1'b0;
         pulse_r   <= 1'b0;
         run_val_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         len_r     <= len_s;
         z_r       <= z_s;
         pulse_r   <= pulse_s;
         run_val_r <= (state_s == RUN1);
      end
   end

   assign z       = z_r;
   assign z_pulse = pulse_r;
   assign run_val = run_val_r;
   assign run_len = len_r;
   assign state   = state_r;

`ifdef RUN_DET_EVENT_CNT_EN
   logic inc0_s, inc1_s;
   assign inc0_s = pulse_s && (state_s == RUN0);
   assign inc1_s = pulse_s && (state_s == RUN1);

   sat_counter #(.W(CNT_W)) u_hit0 (
      .clk   (clk),
      .reset (reset),
      .inc   (inc0_s),
      .clr   (clear_cnt),
      .count (hit0_cnt)
   );

   sat_counter #(.W(CNT_W)) u_hit1 (
      .clk   (clk),
      .reset (reset),
      .inc   (inc1_s),
      .clr   (clear_cnt),
      .count (hit1_cnt)
   );
`else
   logic [CNT_W-1:0] unused_cnt_s;
   assign unused_cnt_s = {CNT_W{clear_cnt}};
`endif

endmodule

// File: tb/tb_run_length_detector.sv
// Self-checking bench for run_length_detector: directed table, corner sequences, random vs. history model.
module tb_run_length_detector;

   localparam int RUN_LEN = 4;
   localparam int CNT_W   = 8;
   localparam int LEN_W   = $clog2(RUN_LEN + 1);
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk;
   logic             reset;
   logic             en;
   logic             w;
   logic             clear_cnt;
   logic             z;
   logic             z_pulse;
   logic             run_val;
   logic [LEN_W-1:0] run_len;
   logic [1:0]       state;
`ifdef RUN_DET_EVENT_CNT_EN
   logic [CNT_W-1:0] hit0_cnt;
   logic [CNT_W-1:0] hit1_cnt;
`endif

   run_length_detector #(.RUN_LEN(RUN_LEN), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .w         (w),
      .clear_cnt (clear_cnt),
      .z         (z),
      .z_pulse   (z_pulse),
      .run_val   (run_val),
      .run_len   (run_len),
      .state     (state)
`ifdef RUN_DET_EVENT_CNT_EN
      ,
      .hit0_cnt  (hit0_cnt),
      .hit1_cnt  (hit1_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: recent sample history plus pulse counts.
   bit hist[$];
   bit m_pulse;
   int m_h0, m_h1;

   function automatic int trail();
      int k;
      k = 0;
      if (hist.size() == 0) return 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
         if (hist[i] != hist[hist.size() - 1]) break;
         k++;
      end
      return k;
   endfunction

   function automatic int m_len();
      int k;
      k = trail();
      return (k > RUN_LEN) ? RUN_LEN : k;
   endfunction

   function automatic int m_state();
      if (hist.size() == 0) return 0;
      return hist[hist.size() - 1] ? 2 : 1;
   endfunction

   task automatic model_update(input bit r, input bit e, input bit wv, input bit c);
      if (!r) begin
         hist.delete();
         m_pulse = 1'b0;
         m_h0 = 0;
         m_h1 = 0;
      end else begin
         m_pulse = 1'b0;
         if (e) begin
            hist.push_back(wv);
            if (hist.size() > RUN_LEN + 1) void'(hist.pop_front());
            m_pulse = (trail() == RUN_LEN);
         end
         if (c) begin
            m_h0 = 0;
            m_h1 = 0;
         end else if (m_pulse) begin
            if (wv) m_h1 = (m_h1 < CNT_MAX) ? m_h1 + 1 : m_h1;
            else    m_h0 = (m_h0 < CNT_MAX) ? m_h0 + 1 : m_h0;
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle(input bit r, input bit e, input bit wv, input bit c);
      reset = r;
      en = e;
      w = wv;
      clear_cnt = c;
      @(posedge clk);
      model_update(r, e, wv, c);
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".z"}, 32'(z), 32'(m_len() == RUN_LEN));
      chk({tag, ".z_pulse"}, 32'(z_pulse), 32'(m_pulse));
      chk({tag, ".run_len"}, 32'(run_len), 32'(m_len()));
      chk({tag, ".run_val"}, 32'(run_val), 32'(m_state() == 2));
      chk({tag, ".state"}, 32'(state), 32'(m_state()));
`ifdef RUN_DET_EVENT_CNT_EN
      chk({tag, ".hit0"}, 32'(hit0_cnt), 32'(m_h0));
      chk({tag, ".hit1"}, 32'(hit1_cnt), 32'(m_h1));
`endif
   endtask

   typedef struct {
      bit r, e, w, c;
      bit z, p;
      int len;
      bit v;
      int st, h0, h1;
   } vec_t;

   vec_t tv[$];

   function automatic void add(bit r, bit e, bit wv, bit z_e, bit p_e, int len_e,
                               bit v_e, int st_e, int h0_e, int h1_e);
      vec_t t;
      t.r = r; t.e = e; t.w = wv; t.c = 1'b0;
      t.z = z_e; t.p = p_e; t.len = len_e; t.v = v_e; t.st = st_e;
      t.h0 = h0_e; t.h1 = h1_e;
      tv.push_back(t);
   endfunction

   initial begin
      bit lastw;
      reset = 1'b0; en = 1'b0; w = 1'b0; clear_cnt = 1'b0;

      // r  e  w   z  p  len v  st h0 h1
      add(0, 0, 0,  0, 0, 0, 0, 0, 0, 0);   // reset
      add(1, 1, 0,  0, 0, 1, 0, 1, 0, 0);   // four zeros
      add(1, 1, 0,  0, 0, 2, 0, 1, 0, 0);
      add(1, 1, 0,  0, 0, 3, 0, 1, 0, 0);
      add(1, 1, 0,  1, 1, 4, 0, 1, 1, 0);
      add(1, 1, 0,  1, 0, 4, 0, 1, 1, 0);   // run continues, saturates
      add(1, 1, 0,  1, 0, 4, 0, 1, 1, 0);
      add(1, 1, 0,  1, 0, 4, 0, 1, 1, 0);
      add(1, 1, 1,  0, 0, 1, 1, 2, 1, 0);   // polarity change
      add(0, 1, 1,  0, 0, 0, 0, 0, 0, 0);   // reset wins over en
      add(1, 1, 1,  0, 0, 1, 1, 2, 0, 0);   // 1,1,1,0,1,1,1,1
      add(1, 1, 1,  0, 0, 2, 1, 2, 0, 0);
      add(1, 1, 1,  0, 0, 3, 1, 2, 0, 0);
      add(1, 1, 0,  0, 0, 1, 0, 1, 0, 0);
      add(1, 1, 1,  0, 0, 1, 1, 2, 0, 0);
      add(1, 1, 1,  0, 0, 2, 1, 2, 0, 0);
      add(1, 1, 1,  0, 0, 3, 1, 2, 0, 0);
      add(1, 1, 1,  1, 1, 4, 1, 2, 0, 1);
      add(0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
      add(1, 1, 0,  0, 0, 1, 0, 1, 0, 0);   // 0,0, en low, 0,0
      add(1, 1, 0,  0, 0, 2, 0, 1, 0, 0);
      add(1, 0, 1,  0, 0, 2, 0, 1, 0, 0);
      add(1, 0, 0,  0, 0, 2, 0, 1, 0, 0);
      add(1, 0, 1,  0, 0, 2, 0, 1, 0, 0);
      add(1, 0, 0,  0, 0, 2, 0, 1, 0, 0);
      add(1, 0, 1,  0, 0, 2, 0, 1, 0, 0);
      add(1, 1, 0,  0, 0, 3, 0, 1, 0, 0);
      add(1, 1, 0,  1, 1, 4, 0, 1, 1, 0);
      add(1, 0, 0,  1, 0, 4, 0, 1, 1, 0);   // en low: z holds, no pulse
      add(0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
      add(1, 1, 1,  0, 0, 1, 1, 2, 0, 0);   // reset mid-run
      add(1, 1, 1,  0, 0, 2, 1, 2, 0, 0);
      add(1, 1, 1,  0, 0, 3, 1, 2, 0, 0);
      add(0, 1, 1,  0, 0, 0, 0, 0, 0, 0);
      add(1, 1, 1,  0, 0, 1, 1, 2, 0, 0);

      foreach (tv[i]) begin
         cycle(tv[i].r, tv[i].e, tv[i].w, tv[i].c);
         chk($sformatf("tv%0d.z", i), 32'(z), 32'(tv[i].z));
         chk($sformatf("tv%0d.z_pulse", i), 32'(z_pulse), 32'(tv[i].p));
         chk($sformatf("tv%0d.run_len", i), 32'(run_len), 32'(tv[i].len));
         chk($sformatf("tv%0d.run_val", i), 32'(run_val), 32'(tv[i].v));
         chk($sformatf("tv%0d.state", i), 32'(state), 32'(tv[i].st));
`ifdef RUN_DET_EVENT_CNT_EN
         chk($sformatf("tv%0d.hit0", i), 32'(hit0_cnt), 32'(tv[i].h0));
         chk($sformatf("tv%0d.hit1", i), 32'(hit1_cnt), 32'(tv[i].h1));
`endif
      end

      // 256 detections of ones: counter must stick at all-ones.
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      for (int n = 0; n < 256; n++) begin
         for (int k = 0; k < RUN_LEN; k++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b0);
            check_model("sat");
         end
         cycle(1'b1, 1'b1, 1'b0, 1'b0);
         check_model("sat");
      end
`ifdef RUN_DET_EVENT_CNT_EN
      chk("hit1_saturated", 32'(hit1_cnt), 32'(CNT_MAX));
`endif

      // Clear coinciding with a detection pulse.
      for (int k = 0; k < RUN_LEN - 1; k++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b1);
      chk("clr_pulse.z_pulse", 32'(z_pulse), 32'd1);
`ifdef RUN_DET_EVENT_CNT_EN
      chk("clr_pulse.hit1", 32'(hit1_cnt), 32'd0);
      chk("clr_pulse.hit0", 32'(hit0_cnt), 32'd0);
`endif
      check_model("clr");

      // Random traffic with run-biased data.
      lastw = 1'b0;
      for (int n = 0; n < 600; n++) begin
         bit r, e, c;
         r = ($urandom_range(0, 59) != 0);
         e = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 3) == 0) lastw = ~lastw;
         cycle(r, e, lastw, c);
         check_model("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
